// File: rtl/costas_pkg.sv
// Shared constants and fixed-point types for the Costas carrier-recovery loop.
package costas_pkg;

    localparam int PHASE_W   = 32;  // phase accumulator width
    localparam int LUT_AW    = 8;   // quarter-wave ROM address width
    localparam int OUT_W     = 16;  // reference sample width
    localparam int CTRL_W    = 18;  // loop-filter correction width
    localparam int CTRL_FRAC = 15;  // fractional bits of the correction

    // Oscillator reference sample, sfix16_15.
    typedef logic signed [OUT_W-1:0] sample_t;

    // Loop-filter correction, sfix18_15; also the loop filter's output type.
    typedef logic signed [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/nco_qwave_rom.sv
// Quarter-wave sine magnitude ROM with two registered read ports.
// Entry k holds round(AMP * sin((k + 0.5) * (pi/2) / DEPTH)); the half-step
// offset keeps every entry non-zero and symmetric about the quadrant edges.
module nco_qwave_rom #(
    parameter int AW = 8,
    parameter int DW = 15
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    output logic [DW-1:0] dout_a,
    output logic [DW-1:0] dout_b
);

    localparam int  DEPTH = 1 << AW;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = real'((1 << DW) - 1);

    function automatic logic [DEPTH*DW-1:0] build_rom();
        logic [DEPTH*DW-1:0] bits;
        real                 ang;
        integer              val;
        bits = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ang = (real'(k) + 0.5) * PI / (2.0 * real'(DEPTH));
            val = $rtoi(AMP * $sin(ang) + 0.5);
            bits[k*DW +: DW] = DW'(val);
        end
        return bits;
    endfunction

    localparam logic [DEPTH*DW-1:0] ROM_BITS = build_rom();

    // Registered dual read of the constant table.
    // NOTE: the read registers carry no reset; the sample-valid pipeline decides
    // when their contents matter, which keeps this mappable onto block ROM.
    always_ff @(posedge clk) begin
        dout_a <= ROM_BITS[addr_a*DW +: DW];
        dout_b <= ROM_BITS[addr_b*DW +: DW];
    end

endmodule

// File: rtl/costas_nco.sv
// Costas-loop NCO: phase accumulator steered by the latched loop-filter
// correction, followed by a 3-stage quarter-wave cos/sin generator.
module costas_nco
    import costas_pkg::*;
#(
    parameter int PHASE_W    = costas_pkg::PHASE_W,
    parameter int LUT_AW     = costas_pkg::LUT_AW,
    parameter int OUT_W      = costas_pkg::OUT_W,
    parameter int GAIN_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PHASE_W-1:0]      base_inc,
    input  ctrl_t                   ctrl,
    input  logic                    ctrl_valid,
    input  logic                    ctrl_clr,
    input  logic                    adv,
    output logic signed [OUT_W-1:0] cos_out,
    output logic signed [OUT_W-1:0] sin_out,
    output logic                    out_valid
);

    ctrl_t                   ctrl_q;
    logic [PHASE_W-1:0]      phase_q;
    logic [PHASE_W-1:0]      corr_ext;
    logic [PHASE_W-1:0]      inc;
    logic [1:0]              quad_s0_q, quad_s1_q;
    logic [LUT_AW-1:0]       idx_s0_q;
    logic                    vld_s0_q, vld_s1_q, vld_s2_q;
    logic [OUT_W-2:0]        rom_a, rom_b;
    logic signed [OUT_W-1:0] mag_a, mag_b;
    logic signed [OUT_W-1:0] sin_d, cos_d;
    logic signed [OUT_W-1:0] sin_q, cos_q;

    // Correction register: clear opens the loop and beats a coincident load.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else if (ctrl_clr) begin
            ctrl_q <= '0;
        end else if (ctrl_valid) begin
            ctrl_q <= ctrl;
        end
    end

    // Increment from the registered correction, so a same-cycle load lands on
    // the following advance.
    assign corr_ext = {{(PHASE_W-CTRL_W){ctrl_q[CTRL_W-1]}}, ctrl_q};
    assign inc      = base_inc + (corr_ext << GAIN_SHIFT);

    // S0: capture quadrant and table index of the current phase, then step it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= '0;
            quad_s0_q <= '0;
            idx_s0_q  <= '0;
            vld_s0_q  <= 1'b0;
        end else begin
            vld_s0_q <= adv;
            if (adv) begin
                quad_s0_q <= phase_q[PHASE_W-1 -: 2];
                idx_s0_q  <= phase_q[PHASE_W-3 -: LUT_AW];
                phase_q   <= phase_q + inc;
            end
        end
    end

    // S1: table lookups of L[i] and L[~i].
    nco_qwave_rom #(
        .AW (LUT_AW),
        .DW (OUT_W-1)
    ) u_rom (
        .clk    (clk),
        .addr_a (idx_s0_q),
        .addr_b (~idx_s0_q),
        .dout_a (rom_a),
        .dout_b (rom_b)
    );

    // S1: carry quadrant and valid alongside the table read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quad_s1_q <= '0;
            vld_s1_q  <= 1'b0;
        end else begin
            quad_s1_q <= quad_s0_q;
            vld_s1_q  <= vld_s0_q;
        end
    end

    assign mag_a = signed'({1'b0, rom_a});
    assign mag_b = signed'({1'b0, rom_b});

    // Quadrant mapping by swap and negate; magnitudes never reach full scale,
    // so negation cannot overflow.
    // NOTE: both outputs get a default first, so no path can infer a latch.
    always_comb begin
        sin_d = mag_a;
        cos_d = mag_b;
        unique case (quad_s1_q)
            2'd0: begin sin_d =  mag_a; cos_d =  mag_b; end
            2'd1: begin sin_d =  mag_b; cos_d = -mag_a; end
            2'd2: begin sin_d = -mag_a; cos_d = -mag_b; end
            2'd3: begin sin_d = -mag_b; cos_d =  mag_a; end
            default: ;
        endcase
    end

    // S2: output registers hold the last sample between advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_q    <= '0;
            cos_q    <= '0;
            vld_s2_q <= 1'b0;
        end else begin
            vld_s2_q <= vld_s1_q;
            if (vld_s1_q) begin
                sin_q <= sin_d;
                cos_q <= cos_d;
            end
        end
    end

    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign out_valid = vld_s2_q;

endmodule

// File: tb/tb_costas_nco.sv
// Directed bench for costas_nco: reset, quadrant stepping, wrap, correction,
// same-cycle update, clear priority and a full-rate 1024-sample stream.
module tb_costas_nco;
    import costas_pkg::*;

    logic               clk;
    logic               rst_n;
    logic [31:0]        base_inc;
    ctrl_t              ctrl;
    logic               ctrl_valid;
    logic               ctrl_clr;
    logic               adv;
    logic signed [15:0] cos_out;
    logic signed [15:0] sin_out;
    logic               out_valid;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int got_s[$], got_c[$], got_cyc[$];
    int exp_s[$], exp_c[$];

    costas_nco dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .base_inc   (base_inc),
        .ctrl       (ctrl),
        .ctrl_valid (ctrl_valid),
        .ctrl_clr   (ctrl_clr),
        .adv        (adv),
        .cos_out    (cos_out),
        .sin_out    (sin_out),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every emitted sample together with the cycle it appeared in.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            got_s.push_back(int'(sin_out));
            got_c.push_back(int'(cos_out));
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference table straight from the defining formula.
    function automatic int lut(input int k);
        real x;
        x = 32767.0 * $sin((real'(k) + 0.5) * 3.14159265358979323846 / 512.0);
        return $rtoi(x + 0.5);
    endfunction

    task automatic expect_pair(input int s, input int c);
        exp_s.push_back(s);
        exp_c.push_back(c);
    endtask

    task automatic expect_phase(input logic [31:0] ph);
        int a, b;
        logic [7:0] i;
        i = ph[29:22];
        a = lut(int'(i));
        b = lut(255 - int'(i));
        case (ph[31:30])
            2'd0: expect_pair( a,  b);
            2'd1: expect_pair( b, -a);
            2'd2: expect_pair(-a, -b);
            default: expect_pair(-b, a);
        endcase
    endtask

    task automatic clear_queues();
        got_s.delete(); got_c.delete(); got_cyc.delete();
        exp_s.delete(); exp_c.delete();
    endtask

    // Compare captured samples against expectations; samples must appear
    // contiguously starting three cycles after the first advance.
    task automatic verify(input string tag, input int first);
        int n;
        check($sformatf("%s_count", tag), got_s.size(), exp_s.size());
        n = (got_s.size() < exp_s.size()) ? got_s.size() : exp_s.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_sin%0d", tag, k), got_s[k], exp_s[k]);
            check($sformatf("%s_cos%0d", tag, k), got_c[k], exp_c[k]);
            check($sformatf("%s_cyc%0d", tag, k), got_cyc[k], first + 3 + k);
        end
        clear_queues();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; holds adv for n consecutive rising edges.
    task automatic run_advs(input int n, output int first);
        first = cyc;
        adv = 1'b1;
        repeat (n) @(negedge clk);
        adv = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        adv        = 1'b0;
        ctrl_valid = 1'b0;
        ctrl_clr   = 1'b0;
        ctrl       = '0;
        idle(2);
        clear_queues();
        rst_n = 1'b1;
    endtask

    initial begin
        int first;
        longint pwr;
        rst_n      = 1'b0;
        base_inc   = '0;
        ctrl       = '0;
        ctrl_valid = 1'b0;
        ctrl_clr   = 1'b0;
        adv        = 1'b0;
        idle(2);

        // Reset state.
        check("rst_sin", sin_out, 0);
        check("rst_cos", cos_out, 0);
        check("rst_valid", out_valid, 0);
        rst_n = 1'b1;

        // Mid-stream asynchronous reset, then first sample after release.
        base_inc = 32'h4000_0000;
        adv = 1'b1;
        idle(5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sin", sin_out, 0);
        check("midrst_cos", cos_out, 0);
        check("midrst_valid", out_valid, 0);
        @(negedge clk);
        idle(1);
        clear_queues();
        rst_n = 1'b1;
        first = cyc;
        @(negedge clk);
        adv = 1'b0;
        idle(6);
        expect_pair(101, 32767);
        verify("rst_first", first);

        // Quarter-turn steps through all four quadrants.
        do_reset();
        base_inc = 32'h4000_0000;
        run_advs(4, first);
        idle(6);
        expect_pair(101, 32767);
        expect_pair(32767, -101);
        expect_pair(-101, -32767);
        expect_pair(-32767, 101);
        verify("quarter", first);

        // Three-quarter steps wrap back to phase 0 on the fifth sample.
        do_reset();
        base_inc = 32'hC000_0000;
        run_advs(5, first);
        idle(6);
        expect_pair(101, 32767);
        expect_pair(-32767, 101);
        expect_pair(-101, -32767);
        expect_pair(32767, -101);
        expect_pair(101, 32767);
        verify("wrap", first);

        // Positive correction +1.0 steps the phase by 2^23.
        do_reset();
        base_inc = '0;
        ctrl = 18'sh08000;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
        run_advs(5, first);
        idle(6);
        expect_phase(32'h0000_0000);
        expect_phase(32'h0080_0000);
        expect_phase(32'h0100_0000);
        expect_phase(32'h0180_0000);
        expect_phase(32'h0200_0000);
        verify("corr_pos", first);

        // Negative correction -1.0 wraps downward from 0.
        do_reset();
        ctrl = 18'sh38000;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
        run_advs(3, first);
        idle(6);
        expect_phase(32'h0000_0000);
        expect_phase(32'hFF80_0000);
        expect_phase(32'hFF00_0000);
        verify("corr_neg", first);

        // Load coincident with adv takes effect one advance later.
        do_reset();
        ctrl = 18'sh08000;
        ctrl_valid = 1'b1;
        adv = 1'b1;
        first = cyc;
        @(negedge clk);
        ctrl_valid = 1'b0;
        idle(2);
        adv = 1'b0;
        idle(6);
        expect_phase(32'h0000_0000);
        expect_phase(32'h0000_0000);
        expect_phase(32'h0080_0000);
        verify("same_cyc", first);

        // Clear and load together: clear wins, phase stops moving.
        ctrl = 18'sh10000;
        ctrl_clr = 1'b1;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_clr = 1'b0;
        ctrl_valid = 1'b0;
        run_advs(2, first);
        idle(6);
        expect_phase(32'h0100_0000);
        expect_phase(32'h0100_0000);
        verify("clr_wins", first);

        // Full-rate stream walking every table entry in every quadrant.
        do_reset();
        base_inc = 32'h0040_0000;
        run_advs(1024, first);
        idle(6);
        for (int k = 0; k < 1024; k++) expect_phase(32'(k) << 22);
        for (int k = 0; k < got_s.size(); k++) begin
            pwr = longint'(got_s[k]) * got_s[k] + longint'(got_c[k]) * got_c[k];
            check($sformatf("stream_pwr%0d", k),
                  (pwr >= 64'd1073610756 && pwr <= 64'd1073741825) ? 1 : 0, 1);
        end
        verify("stream", first);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/costas_nco.md
# costas_nco

Numerically controlled oscillator that closes the Costas carrier-recovery loop. It accumulates phase from a nominal frequency word plus the latched sfix18_15 loop-filter correction. A quarter-wave sine ROM converts the phase into cos/sin reference samples for the downconversion mixer. Each oscillator sample is produced on an `adv` strobe, so the NCO runs at the IQ sample rate and the correction updates asynchronously to it.

## Interface
- `PHASE_W`, 32: phase accumulator width. Wraps modulo 2^PHASE_W.
- `LUT_AW`, 8: quarter-wave ROM address width (256 entries).
- `OUT_W`, 16: cos/sin sample width, sfix16_15.
- `GAIN_SHIFT`, 8: left shift applied to the sign-extended correction before it is added to the increment.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `base_inc` in PHASE_W: nominal phase increment, unsigned, quasi-static.
- `ctrl` in 18: loop-filter correction, sfix18_15.
- `ctrl_valid` in 1: single-cycle strobe that latches `ctrl`.
- `ctrl_clr` in 1: forces the latched correction to 0 (loop open). Has priority over `ctrl_valid`.
- `adv` in 1: advance strobe; one output sample per high cycle.
- `cos_out` out OUT_W: cosine sample, sfix16_15.
- `sin_out` out OUT_W: sine sample, sfix16_15.
- `out_valid` out 1: one cycle per sample.

## Operation
- **Correction register `ctrl_r`** (18b):
  - `ctrl_clr` → 0.
  - else `ctrl_valid` → `ctrl`.
  - else hold.
- **Phase increment:** inc = `base_inc` + (sext_PHASE_W(`ctrl_r`) << GAIN_SHIFT), modulo 2^PHASE_W. Uses the registered `ctrl_r`. A `ctrl_valid` in the same cycle as `adv` takes effect on the next `adv`.
- **Accumulator `phase`:** on `adv`, `phase <= phase + inc` (natural wrap). Otherwise hold.
- **Sample phase:** the sample emitted for an `adv` uses `phase` before that update. The first sample after reset uses phase 0.
- **Address decode:** q = `phase`[PHASE_W-1:PHASE_W-2]; i = `phase`[PHASE_W-3 -: LUT_AW]; ~i = 255 − i. Lower phase bits are truncated, with no dither.
- **ROM:** L[k] = round(32767·sin((k+0.5)·π/512)), k = 0..255. Every entry is in 101..32767, so negation never overflows.
- **Quadrant mapping:**
  - q0: sin = L[i], cos = L[~i]
  - q1: sin = L[~i], cos = −L[i]
  - q2: sin = −L[i], cos = −L[~i]
  - q3: sin = −L[~i], cos = L[i]
- **Output behaviour:** outputs hold their last value between samples. Back-to-back `adv` every cycle gives full throughput.

## Timing
- **Pipeline (3 stages):**
  - S0: latch q and i from `phase`, then update `phase`.
  - S1: registered ROM read of L[i] and L[~i].
  - S2: quadrant sign/swap, output registers.
- **Latency:** `adv` high in cycle N → `out_valid` high in cycle N+3 for exactly one cycle. Valid follows `adv` through a 3-deep shift.
- **Reset (async assert):**
  - `phase`, `ctrl_r`, pipeline regs, `cos_out`, `sin_out` = 0.
  - `out_valid` = 0.
  - In-flight samples are discarded.
- **Reset release:** the first `adv` is accepted on the first rising edge with `rst_n` high.
- **Simultaneous `ctrl_clr` and `ctrl_valid`:** clear wins.
- **Wrap-around:** silent, modulo 2^PHASE_W. No flag.

## Structure
- **Package `costas_pkg`:**
  - PHASE_W, LUT_AW, OUT_W, CTRL_W = 18 and CTRL_FRAC = 15 constants.
  - Typedef for the sfix16_15 sample.
  - Typedef for the sfix18_15 correction; this type is shared with the loop filter output.
- **Sub-module `nco_qwave_rom`:**
  - Dual-read synchronous ROM, 256×15 (magnitude only).
  - Ports: clk, addr_a, addr_b, dout_a, dout_b.
  - Contents generated from the L[k] formula at elaboration.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with `adv` toggling → all outputs 0 immediately. After release, the first `adv` yields `sin_out`=101, `cos_out`=32767 at N+3.
- **Quarter-step:** `base_inc`=0x4000_0000, `ctrl_r`=0, four consecutive `adv` → (sin, cos) sequence (101, 32767), (32767, −101), (−101, −32767), (−32767, 101), with `out_valid` high cycles N+3..N+6.
- **Wrap:** `base_inc`=0xC000_0000 → phases 0, 0xC000_0000, 0x8000_0000, 0x4000_0000, 0. Sample 5 equals sample 1.
- **Correction:** `base_inc`=0, `ctrl`=18'sh08000 (+1.0) pulsed with `ctrl_valid`, then 4 `adv` → `phase` = 0, 2^23, 2^24, 3·2^23, 2^25. With `ctrl`=18'sh38000 (−1.0), `phase` decrements by 2^23 per `adv` and wraps to 0xFF80_0000 from 0.
- **Same-cycle update and clear:**
  - `ctrl_valid` (+1.0) coincident with `adv`, `base_inc`=0 → that step adds 0 and the next adds 2^23.
  - `ctrl_clr` and `ctrl_valid` together → `ctrl_r`=0.
- **Sustained stream:** `adv` held high 1024 cycles, `base_inc`=0x0040_0000 → 1024 contiguous `out_valid` cycles. Every cos²+sin² lies in [32766², 32767²+ε], matching a golden model bit-exactly.
